tim_ram_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous RAM (16 x 8, registered read, enable + write-enable) among NUM_REQ requesters. It accepts at most one read or write command per cycle, registers the command onto the RAM ports, and routes read data back with a one-hot rvalid. It sits between client blocks and the RAM and is the only driver of the RAM ports.

---
 rtl/tim_ram_pkg.sv | 23 ++
 rtl/tim_rr_arb.sv | 27 ++
 rtl/tim_ram_arbiter.sv | 84 ++++++++
 tb/tb_tim_ram_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tim_ram_pkg.sv
// Shared widths and response-pipeline entry type for the RAM arbiter slice.
package tim_ram_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_REQ    = 4;

  // Requester ids are sized for the largest supported requester count so the
  // pipeline entry type can live here, independent of the top's NUM_REQ.
  localparam int REQ_ID_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } resp_entry_t;

  function automatic logic [REQ_ID_W-1:0] next_id(input logic [REQ_ID_W-1:0] id,
                                                  input int num_req);
    if (int'(id) >= num_req - 1) return '0;
    return id + REQ_ID_W'(1);
  endfunction

endpackage

// File: rtl/tim_rr_arb.sv
// Combinational round-robin pick: scans upward from ptr with wrap, first requester wins.
module tim_rr_arb
  import tim_ram_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [REQ_ID_W-1:0] winner,
  output logic                found
);

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NUM_REQ]) begin
        found  = 1'b1;
        winner = REQ_ID_W'((int'(ptr) + off) % NUM_REQ);
        gnt[(int'(ptr) + off) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tim_ram_arbiter.sv
// Round-robin sharing of one single-port registered-read RAM among NUM_REQ requesters.
module tim_ram_arbiter
  import tim_ram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_e,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_di,
  input  logic [DATA_W-1:0]         ram_do
);

  logic [REQ_ID_W-1:0] ptr;
  logic [REQ_ID_W-1:0] winner;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic                found;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  resp_entry_t         stage1;
  resp_entry_t         stage2;

  tim_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .winner (winner),
    .found  (found)
  );

  // Grants are suppressed during reset so nothing transfers on a reset edge.
  assign gnt       = rst_n ? arb_gnt : '0;
  assign accept    = rst_n & found;
  assign sel_we    = we[int'(winner)];
  assign sel_addr  = addr[int'(winner)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(winner)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      ram_e    <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_di   <= '0;
      stage1   <= '0;
      stage2   <= '0;
    end else begin
      ram_e        <= accept;
      ram_we       <= accept & sel_we;
      stage1.valid <= accept & ~sel_we;
      stage1.id    <= winner;
      stage2       <= stage1;
      if (accept) begin
        ptr      <= next_id(winner, NUM_REQ);
        ram_addr <= sel_addr;
        ram_di   <= sel_wdata;
      end
    end
  end

  // stage2 lines up with the cycle in which the RAM's registered output is valid.
  always_comb begin
    rvalid = '0;
    if (stage2.valid) rvalid[int'(stage2.id)] = 1'b1;
  end

  assign rdata = ram_do;

endmodule

// File: tb/tb_tim_ram_arbiter.sv
// Randomized and directed checks of tim_ram_arbiter against a transaction-level model.
module tb_tim_ram_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } resp_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req, we, gnt, rvalid;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]         rdata, ram_di, ram_do;
  logic [ADDR_W-1:0]         ram_addr;
  logic                      ram_e, ram_we;

  logic [7:0] ram_mem   [16];
  logic [7:0] model_mem [16];
  resp_t      pend [$];
  int         model_ptr;
  int         model_last_k;
  logic       exp_ram_e, exp_ram_we;
  logic [3:0] exp_ram_addr;
  logic [7:0] exp_ram_di;
  int         cycle;
  int         checks;
  int         failures;

  bit         p_act [NUM_REQ];
  logic       p_we  [NUM_REQ];
  logic [3:0] p_addr[NUM_REQ];
  logic [7:0] p_data[NUM_REQ];

  tim_ram_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_e    (ram_e),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read; reset does not touch it.
  always @(posedge clk) begin
    if (ram_e) begin
      if (ram_we) ram_mem[ram_addr] <= ram_di;
      else        ram_do <= ram_mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  // Drives one cycle, checks this cycle's outputs, then advances the model over the edge.
  task automatic applyStimulus(input logic rs, input logic [1:0] r, input logic [1:0] w,
                               input logic [7:0] a, input logic [15:0] d);
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    logic [7:0] exp_rd;
    logic [3:0] a_k;
    logic [7:0] d_k;
    int         k;
    rst_n = rs;
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    #1;
    k = -1;
    if (rs) begin
      for (int off = 0; off < NUM_REQ; off++)
        if (k < 0 && r[(model_ptr + off) % NUM_REQ]) k = (model_ptr + off) % NUM_REQ;
    end
    exp_gnt = '0;
    if (k >= 0) exp_gnt[k] = 1'b1;
    exp_rv = '0;
    exp_rd = '0;
    if (pend.size() > 0 && pend[0].due == cycle) begin
      exp_rv[pend[0].id] = 1'b1;
      exp_rd = pend[0].data;
      void'(pend.pop_front());
    end
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != 0) checkOutput("rdata", 32'(rdata), 32'(exp_rd));
    checkOutput("ram_e", 32'(ram_e), 32'(exp_ram_e));
    checkOutput("ram_we", 32'(ram_we), 32'(exp_ram_we));
    if (exp_ram_e) checkOutput("ram_addr", 32'(ram_addr), 32'(exp_ram_addr));
    if (exp_ram_we) checkOutput("ram_di", 32'(ram_di), 32'(exp_ram_di));

    model_last_k = -1;
    if (!rs) begin
      model_ptr = 0;
      pend.delete();
      exp_ram_e  = 1'b0;
      exp_ram_we = 1'b0;
    end else if (k >= 0) begin
      a_k = a[k*4 +: 4];
      d_k = d[k*8 +: 8];
      exp_ram_e    = 1'b1;
      exp_ram_we   = w[k];
      exp_ram_addr = a_k;
      exp_ram_di   = d_k;
      if (w[k]) model_mem[a_k] = d_k;
      else      pend.push_back('{cycle + 2, k, model_mem[a_k]});
      model_ptr    = (k + 1) % NUM_REQ;
      model_last_k = k;
    end else begin
      exp_ram_e  = 1'b0;
      exp_ram_we = 1'b0;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cycle = 0;
    model_ptr = 0;
    exp_ram_e = 1'b0;
    exp_ram_we = 1'b0;
    exp_ram_addr = '0;
    exp_ram_di = '0;
    ram_do = '0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i]   = 8'(i * 7 + 3);
      model_mem[i] = 8'(i * 7 + 3);
    end
    rst_n = 1'b0;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000);

    // Write then read addr 3 from requester 0.
    applyStimulus(1'b1, 2'b01, 2'b01, 8'h03, 16'h00A5);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h03, 16'h0000);
    idleCycles(3);

    // Both requesters reading continuously from a fresh pointer.
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b11, 2'b00, 8'h21, 16'h0000);
    idleCycles(3);

    // Back-to-back reads from requester 0.
    applyStimulus(1'b1, 2'b01, 2'b01, 8'h01, 16'h0011);
    applyStimulus(1'b1, 2'b01, 2'b01, 8'h02, 16'h0022);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h01, 16'h0000);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h02, 16'h0000);
    idleCycles(3);

    // Read-before-write ordering on addr 5.
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1'b1, 2'b01, 2'b01, 8'h05, 16'h0011);
    applyStimulus(1'b1, 2'b11, 2'b10, 8'h55, 16'h2200);
    applyStimulus(1'b1, 2'b10, 2'b10, 8'h55, 16'h2200);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h05, 16'h0000);
    idleCycles(3);

    // Reset right after a read accept discards the response.
    applyStimulus(1'b1, 2'b10, 2'b00, 8'h40, 16'h0000);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h07, 16'h0000);
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1'b1, 2'b11, 2'b00, 8'h98, 16'h0000);
    idleCycles(3);

    idleCycles(10);

    for (int i = 0; i < NUM_REQ; i++) p_act[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [1:0]  r, w;
      logic [7:0]  a;
      logic [15:0] d;
      logic        rs;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!p_act[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            p_act[i]  = 1'b1;
            p_we[i]   = 1'($urandom_range(0, 1));
            p_addr[i] = 4'($urandom_range(0, 15));
            p_data[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          p_act[i] = 1'b0;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        r[i]         = p_act[i];
        w[i]         = p_act[i] ? p_we[i] : 1'b0;
        a[i*4 +: 4]  = p_act[i] ? p_addr[i] : 4'h0;
        d[i*8 +: 8]  = p_act[i] ? p_data[i] : 8'h00;
      end
      rs = ($urandom_range(0, 49) != 0);
      applyStimulus(rs, r, w, a, d);
      if (model_last_k >= 0) p_act[model_last_k] = 1'b0;
    end
    idleCycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
